// File: rtl/parking_exit_ctrl.sv
// parking_exit_ctrl: exit barrier FSM with ticket check, retry lockout and lot occupancy counting.
module parking_exit_ctrl #(
    parameter int         CAPACITY  = 8,
    parameter int         TIMEOUT   = 16,
    parameter logic [1:0] PASS_CODE = 2'b10,
    parameter int         MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       exit_sensor,
    input  logic       gate_clear,
    input  logic [1:0] ticket,
    input  logic       ticket_valid,
    input  logic       entry_done,
    input  logic       attendant_clr,
    output logic       GREEN_LED,
    output logic       RED_LED,
    output logic       gate_open,
    output logic       alarm,
    output logic [3:0] occupancy,
    output logic       lot_full,
    output logic       lot_empty
);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] WAIT_TICKET = 3'd1;
    localparam logic [2:0] OPEN        = 3'd2;
    localparam logic [2:0] DENIED      = 3'd3;
    localparam logic [2:0] LOCKOUT     = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          blink_q, blink_d;
    logic [3:0]    occ_q, occ_d;
    logic          dec;

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        retry_d = retry_q;
        blink_d = 1'b0;
        case (state_q)
            IDLE: if (exit_sensor && occ_q != 4'd0) state_d = WAIT_TICKET;
            WAIT_TICKET, DENIED: begin
                wait_d = wait_q + 1'b1;
                if (ticket_valid) begin
                    if (ticket == PASS_CODE) begin
                        state_d = OPEN;
                        retry_d = '0;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = (retry_d == RW'(MAX_RETRY)) ? LOCKOUT : DENIED;
                        wait_d  = '0;
                        blink_d = (retry_d != RW'(MAX_RETRY));
                    end
                end else if (wait_q == WW'(TIMEOUT - 1)) begin
                    // first timeout demotes to DENIED, second abandons the transaction
                    state_d = (state_q == WAIT_TICKET) ? DENIED : IDLE;
                    retry_d = (state_q == WAIT_TICKET) ? retry_q : '0;
                    wait_d  = '0;
                    blink_d = (state_q == WAIT_TICKET);
                end else begin
                    blink_d = (state_q == DENIED) ? ~blink_q : 1'b0;
                end
            end
            OPEN: if (gate_clear) state_d = IDLE;
            LOCKOUT: if (attendant_clr) begin
                state_d = IDLE;
                retry_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // a simultaneous entry and exit cancel out, even when the lot is full
    assign dec   = (state_q == OPEN) && gate_clear;
    assign occ_d = (entry_done && dec) ? occ_q :
                   dec ? occ_q - 4'd1 :
                   (entry_done && occ_q != 4'(CAPACITY)) ? occ_q + 4'd1 : occ_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            retry_q <= '0;
            blink_q <= 1'b0;
            occ_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            retry_q <= retry_d;
            blink_q <= blink_d;
            occ_q   <= occ_d;
        end
    end

    assign GREEN_LED = (state_q == OPEN);
    assign gate_open = (state_q == OPEN);
    assign alarm     = (state_q == LOCKOUT);
    assign RED_LED   = (state_q == WAIT_TICKET) || (state_q == LOCKOUT) ||
                       ((state_q == DENIED) && blink_q);
    assign occupancy = occ_q;
    assign lot_full  = (occ_q == 4'(CAPACITY));
    assign lot_empty = (occ_q == 4'd0);
endmodule
